interconnect_link_sender: RTL and testbench
===========================================

// Module: interconnect_link_sender
// PURPOSE
// - Transmit end of an interconnect link: per-physical-plane output queue driving reqs/tag_lines/data_lines.
// - Pops an entry on ack; sits between a PE output channel and an interconnect_link_if.sender modport.
// - Decouples the PE from downstream backpressure; one independent FIFO per plane, no cross-plane ordering.
// PARAMETERS
// - DEPTH  2  entries per plane FIFO; power of two, >= 2
// - TIA_NUM_PHYSICAL_PLANES / TIA_TAG_WIDTH / TIA_WORD_WIDTH  package constants, not overridden here
// PORTS
// - clock        input   1        single clock, all state on rising edge
// - reset        input   1        synchronous, active-high
// - enq_valid    input   [P-1:0]  per-plane enqueue request (P = TIA_NUM_PHYSICAL_PLANES)
// - enq_ready    output  [P-1:0]  per-plane queue not full
// - enq_tag      input   [P-1:0][TIA_TAG_WIDTH-1:0]   tag to enqueue
// - enq_data     input   [P-1:0][TIA_WORD_WIDTH-1:0]  word to enqueue
// - output_interconnect_link  interconnect_link_if.sender  -  drives reqs/tag_lines/data_lines, samples acks
// - quiescent    output  1        all plane queues empty
// BEHAVIOUR
// - Link handshake: a transfer on plane p occurs at a rising edge where reqs[p] && acks[p]; acks may be high with req low (ignored).
// - reqs[p] = (count[p] != 0); tag_lines[p]/data_lines[p] = head entry when count != 0, else all zeros.
// - Once reqs[p] is asserted, it and tag/data hold stable until the transfer edge (no retraction).
// - enq_ready[p] = (count[p] < DEPTH); purely from state, no combinational path from acks or enq_valid.
// - Enqueue when enq_valid[p] && enq_ready[p]: write tail, tail <= tail+1 mod DEPTH.
// - Dequeue on transfer: head <= head+1 mod DEPTH.
// - count: +1 on enqueue only, -1 on dequeue only, unchanged on both same edge.
// - Full: enq_ready=0, enq_valid ignored even if the same edge dequeues; ready reasserts the cycle after.
// - Empty: reqs=0; an enqueue at edge N gives reqs=1 in cycle N+1 (latency 1, no pass-through).
// - Pointer wrap: head/tail are log2(DEPTH) bits, natural overflow; count is log2(DEPTH)+1 bits.
// - quiescent = all count==0.
// - Reset (any cycle, incl. mid-handshake): count/head/tail <= 0; reqs=0, tag/data=0, enq_ready=all 1, quiescent=1.
// - Entry storage is not reset; pending entries are discarded.
// - Per-plane state is fully independent; stalls on one plane never affect another.
// - X on enq_tag/enq_data when not enqueuing must not propagate to outputs.
// CONFIGURATION
// - TIA_LINK_SENDER_STATS_EN defined: adds output stall_count [P-1:0][15:0].
// - stall_count increments in each cycle with reqs[p] && !acks[p], saturates at 16'hFFFF, reset to 0.
// - TIA_LINK_SENDER_STATS_EN undefined: port and counters absent; all other behaviour identical.
// TESTING
// - Reset then idle 5 cycles -> reqs=0, tag/data=0, enq_ready=all 1, quiescent=1.
// - Plane 0: enq tag=3, data=0xA5A5A5A5; acks[0]=1 -> reqs[0] high the next cycle with tag 3 and data 0xA5A5A5A5.
//   - Transfer happens the cycle after; quiescent returns 1.
// - Plane 1: acks=0, enqueue data 1,2,3 on consecutive cycles (DEPTH=2) -> enq_ready[1]=0 after 2; data 3 not stored.
//   - Raise acks -> link delivers 1 then 2, in order.
// - Full plane, enq_valid=1 and ack on the same edge -> count goes 2->1; enqueue refused that edge, accepted on the next.
// - Enqueue 5 words with acks toggling 1,0,1,0 -> all 5 delivered in order; head/tail wrap correctly.
//   - Held req keeps data stable while ack=0.
// - Assert reset with 2 entries queued and ack low -> next cycle reqs=0, count=0, quiescent=1, no stale data re-sent.
// - STATS_EN: hold ack low 20 cycles with req high -> stall_count=20; force 70000 stall cycles -> 16'hFFFF.

Source files
------------

// File: rtl/interconnect_link_sender_if.sv
// Package and link interface for the interconnect link sender.
//
// tia_pkg holds the link geometry constants shared by the sender, the
// receiver and the bench.
//
// interconnect_link_if bundles one request/acknowledge pair per physical
// plane together with that plane's tag and data lines.
//   reqs        sender -> receiver   per-plane "head entry is valid"
//   acks        receiver -> sender   per-plane "take the head entry"
//   tag_lines   sender -> receiver   per-plane tag of the head entry
//   data_lines  sender -> receiver   per-plane word of the head entry
// Modports: sender/receiver, with master/slave as equivalent aliases.

package tia_pkg;
  localparam int TIA_NUM_PHYSICAL_PLANES = 2;
  localparam int TIA_TAG_WIDTH           = 4;
  localparam int TIA_WORD_WIDTH          = 32;
endpackage

interface interconnect_link_if;
  import tia_pkg::*;

  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     reqs;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                     acks;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_TAG_WIDTH-1:0]  tag_lines;
  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_WORD_WIDTH-1:0] data_lines;

  modport sender   (output reqs, output tag_lines, output data_lines, input acks);
  modport receiver (input reqs, input tag_lines, input data_lines, output acks);
  modport master   (output reqs, output tag_lines, output data_lines, input acks);
  modport slave    (input reqs, input tag_lines, input data_lines, output acks);
endinterface

// File: rtl/interconnect_link_sender.sv
// interconnect_link_sender
// Transmit end of an interconnect link. Each physical plane owns an
// independent DEPTH-entry FIFO; the head entry is presented on the link
// and popped when the receiver acknowledges it. There is no ordering
// between planes, and a stall on one plane never affects another.
//
// Ports:
//   clock                     rising-edge clock for all state
//   reset                     synchronous, active-high
//   enq_valid[P]              per-plane enqueue request
//   enq_ready[P]              per-plane "queue not full" (state only)
//   enq_tag[P], enq_data[P]   entry to enqueue
//   output_interconnect_link  sender side: drives reqs/tag_lines/data_lines,
//                             samples acks
//   quiescent                 all plane queues empty
//   stall_count[P]            (TIA_LINK_SENDER_STATS_EN only) saturating
//                             count of cycles with reqs && !acks
//
// Optional feature macro: TIA_LINK_SENDER_STATS_EN

module interconnect_link_sender
  import tia_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                 enq_valid,
  output logic [TIA_NUM_PHYSICAL_PLANES-1:0]                 enq_ready,
  input  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_TAG_WIDTH-1:0]  enq_tag,
  input  logic [TIA_NUM_PHYSICAL_PLANES-1:0][TIA_WORD_WIDTH-1:0] enq_data,
  interconnect_link_if.sender                                output_interconnect_link,
  output logic                                               quiescent
`ifdef TIA_LINK_SENDER_STATS_EN
  ,
  output logic [TIA_NUM_PHYSICAL_PLANES-1:0][15:0]           stall_count
`endif
);

  localparam int P     = TIA_NUM_PHYSICAL_PLANES;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TIA_TAG_WIDTH-1:0]  tag_mem  [P][DEPTH];
  logic [TIA_WORD_WIDTH-1:0] data_mem [P][DEPTH];

  logic [PTR_W-1:0] head_q  [P];
  logic [PTR_W-1:0] head_d  [P];
  logic [PTR_W-1:0] tail_q  [P];
  logic [PTR_W-1:0] tail_d  [P];
  logic [CNT_W-1:0] count_q [P];
  logic [CNT_W-1:0] count_d [P];

  logic [P-1:0] not_empty;
  logic [P-1:0] enq_fire;
  logic [P-1:0] deq_fire;

  // Per-plane next-state. Readiness depends only on the registered count,
  // so a dequeue on the same edge never lets a full queue accept.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      not_empty[p] = (count_q[p] != '0);
      enq_ready[p] = (count_q[p] < CNT_W'(DEPTH));
      enq_fire[p]  = enq_valid[p] && enq_ready[p];
      deq_fire[p]  = not_empty[p] && output_interconnect_link.acks[p];

      head_d[p]  = deq_fire[p] ? head_q[p] + PTR_W'(1) : head_q[p];
      tail_d[p]  = enq_fire[p] ? tail_q[p] + PTR_W'(1) : tail_q[p];

      count_d[p] = count_q[p];
      if (enq_fire[p] && !deq_fire[p]) begin
        count_d[p] = count_q[p] + CNT_W'(1);
      end else if (!enq_fire[p] && deq_fire[p]) begin
        count_d[p] = count_q[p] - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers; reset drops any pending entries.
  always_ff @(posedge clock) begin
    for (int p = 0; p < P; p++) begin
      if (reset) begin
        head_q[p]  <= '0;
        tail_q[p]  <= '0;
        count_q[p] <= '0;
      end else begin
        head_q[p]  <= head_d[p];
        tail_q[p]  <= tail_d[p];
        count_q[p] <= count_d[p];
      end
    end
  end

  // Entry storage is deliberately unreset; only written on an accepted
  // enqueue, so undriven enq_tag/enq_data never reach the storage.
  always_ff @(posedge clock) begin
    for (int p = 0; p < P; p++) begin
      if (enq_fire[p] && !reset) begin
        tag_mem[p][tail_q[p]]  <= enq_tag[p];
        data_mem[p][tail_q[p]] <= enq_data[p];
      end
    end
  end

  // Link outputs: the head entry is shown only while the queue holds
  // something, otherwise the lines are forced to zero so unwritten or
  // stale storage is never visible.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      output_interconnect_link.reqs[p]       = not_empty[p];
      output_interconnect_link.tag_lines[p]  = '0;
      output_interconnect_link.data_lines[p] = '0;
      if (not_empty[p]) begin
        output_interconnect_link.tag_lines[p]  = tag_mem[p][head_q[p]];
        output_interconnect_link.data_lines[p] = data_mem[p][head_q[p]];
      end
    end
  end

  assign quiescent = ~|not_empty;

`ifdef TIA_LINK_SENDER_STATS_EN
  logic [15:0] stall_q [P];
  logic [15:0] stall_d [P];

  // Stall counters saturate rather than wrap so a long stall is never
  // mistaken for a short one.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      stall_d[p] = stall_q[p];
      if (not_empty[p] && !output_interconnect_link.acks[p] && (stall_q[p] != 16'hFFFF)) begin
        stall_d[p] = stall_q[p] + 16'd1;
      end
      stall_count[p] = stall_q[p];
    end
  end

  // Stall counter registers.
  always_ff @(posedge clock) begin
    for (int p = 0; p < P; p++) begin
      if (reset) begin
        stall_q[p] <= '0;
      end else begin
        stall_q[p] <= stall_d[p];
      end
    end
  end
`endif

endmodule

// File: tb/tb_interconnect_link_sender.sv
// Testbench for interconnect_link_sender. A per-plane queue model predicts
// reqs, tag/data lines, enq_ready and quiescent for every cycle; directed
// sequences cover the documented corner cases and a randomized run follows.

module tb_interconnect_link_sender;
  import tia_pkg::*;

  localparam int P     = TIA_NUM_PHYSICAL_PLANES;
  localparam int TW    = TIA_TAG_WIDTH;
  localparam int WW    = TIA_WORD_WIDTH;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [WW-1:0] data;
  } entry_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [P-1:0]          enq_valid;
  logic [P-1:0]          enq_ready;
  logic [P-1:0][TW-1:0]  enq_tag;
  logic [P-1:0][WW-1:0]  enq_data;
  logic                  quiescent;
`ifdef TIA_LINK_SENDER_STATS_EN
  logic [P-1:0][15:0]    stall_count;
`endif

  interconnect_link_if link_if ();

  interconnect_link_sender #(.DEPTH(DEPTH)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .enq_valid                (enq_valid),
    .enq_ready                (enq_ready),
    .enq_tag                  (enq_tag),
    .enq_data                 (enq_data),
    .output_interconnect_link (link_if.sender),
    .quiescent                (quiescent)
`ifdef TIA_LINK_SENDER_STATS_EN
    ,
    .stall_count              (stall_count)
`endif
  );

  always #5 clock = ~clock;

  entry_t model_q [P][$];
  int     stall_model [P];
  int     vectors    = 0;
  int     miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Compare every observable output against the queue model.
  task automatic checkState();
    for (int p = 0; p < P; p++) begin
      entry_t head;
      head = (model_q[p].size() != 0) ? model_q[p][0] : '0;
      checkOutput($sformatf("reqs[%0d]", p), 64'(link_if.reqs[p]), 64'(model_q[p].size() != 0));
      checkOutput($sformatf("tag[%0d]", p), 64'(link_if.tag_lines[p]), 64'(head.tag));
      checkOutput($sformatf("data[%0d]", p), 64'(link_if.data_lines[p]), 64'(head.data));
      checkOutput($sformatf("enq_ready[%0d]", p), 64'(enq_ready[p]), 64'(model_q[p].size() < DEPTH));
`ifdef TIA_LINK_SENDER_STATS_EN
      checkOutput($sformatf("stall[%0d]", p), 64'(stall_count[p]), 64'(stall_model[p]));
`endif
    end
    begin
      bit all_empty;
      all_empty = 1'b1;
      for (int p = 0; p < P; p++) if (model_q[p].size() != 0) all_empty = 1'b0;
      checkOutput("quiescent", 64'(quiescent), 64'(all_empty));
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the
  // model across the rising edge using the pre-edge occupancy.
  task automatic applyStimulus(input logic rst, input logic [P-1:0] v, input logic [P-1:0] a,
                               input logic [P-1:0][TW-1:0] t, input logic [P-1:0][WW-1:0] d);
    reset        = rst;
    enq_valid    = v;
    link_if.acks = a;
    enq_tag      = t;
    enq_data     = d;
    @(negedge clock);
    checkState();
    @(posedge clock);
    for (int p = 0; p < P; p++) begin
      int sz;
      sz = model_q[p].size();
      if (rst) begin
        model_q[p].delete();
        stall_model[p] = 0;
      end else begin
        if (sz != 0 && !a[p] && stall_model[p] < 16'hFFFF) stall_model[p]++;
        if (sz != 0 && a[p]) void'(model_q[p].pop_front());
        if (v[p] && sz < DEPTH) model_q[p].push_back('{tag: t[p], data: d[p]});
      end
    end
    #1;
  endtask

  logic [P-1:0]         v, a;
  logic [P-1:0][TW-1:0] t;
  logic [P-1:0][WW-1:0] d;

  task automatic randomData();
    for (int p = 0; p < P; p++) begin
      t[p] = TW'($urandom);
      d[p] = $urandom;
    end
  endtask

  task automatic drainAll();
    int budget;
    budget = 0;
    while ((model_q[0].size() != 0 || model_q[1].size() != 0) && budget < 20) begin
      randomData();
      applyStimulus(1'b0, '0, '1, t, d);
      budget++;
    end
    checkOutput("drain_done", 64'(quiescent), 64'(1));
  endtask

  initial begin
    reset        = 1'b1;
    enq_valid    = '0;
    link_if.acks = '0;
    enq_tag      = '0;
    enq_data     = '0;
    for (int p = 0; p < P; p++) stall_model[p] = 0;
    @(posedge clock);
    #1;

    // Reset then idle five cycles.
    randomData();
    applyStimulus(1'b1, '0, '0, t, d);
    applyStimulus(1'b1, '0, '0, t, d);
    for (int i = 0; i < 5; i++) begin
      randomData();
      applyStimulus(1'b0, '0, 2'($urandom), t, d);
    end
    checkOutput("idle_quiescent", 64'(quiescent), 64'(1));
    checkOutput("idle_ready", 64'(enq_ready), 64'({P{1'b1}}));

    // Plane 0 single entry with ack held high.
    randomData();
    t[0] = 4'd3;
    d[0] = 32'hA5A5A5A5;
    applyStimulus(1'b0, 2'b01, 2'b01, t, d);
    checkOutput("p0_req", 64'(link_if.reqs[0]), 64'(1));
    checkOutput("p0_tag", 64'(link_if.tag_lines[0]), 64'(4'd3));
    checkOutput("p0_data", 64'(link_if.data_lines[0]), 64'(32'hA5A5A5A5));
    randomData();
    applyStimulus(1'b0, '0, 2'b01, t, d);
    checkOutput("p0_quiescent", 64'(quiescent), 64'(1));

    // Plane 1 fill with acks low; third word refused.
    for (int i = 1; i <= 3; i++) begin
      randomData();
      d[1] = WW'(i);
      applyStimulus(1'b0, 2'b10, 2'b00, t, d);
    end
    checkOutput("p1_full", 64'(enq_ready[1]), 64'(0));
    checkOutput("p1_first", 64'(link_if.data_lines[1]), 64'(1));
    randomData();
    applyStimulus(1'b0, '0, 2'b10, t, d);
    checkOutput("p1_second", 64'(link_if.data_lines[1]), 64'(2));
    drainAll();

    // Full plane: enqueue and ack on the same edge, refusal then accept.
    for (int i = 0; i < 2; i++) begin
      randomData();
      applyStimulus(1'b0, 2'b01, 2'b00, t, d);
    end
    randomData();
    d[0] = 32'hDEAD0001;
    applyStimulus(1'b0, 2'b01, 2'b01, t, d);
    checkOutput("full_ready_back", 64'(enq_ready[0]), 64'(1));
    randomData();
    d[0] = 32'hDEAD0002;
    applyStimulus(1'b0, 2'b01, 2'b00, t, d);
    checkOutput("full_accept", 64'(enq_ready[0]), 64'(0));
    drainAll();

    // Five words with acks toggling; exercises pointer wrap and hold.
    begin
      int sent;
      int guard;
      sent  = 0;
      guard = 0;
      while (guard < 40 && (sent < 5 || model_q[0].size() != 0)) begin
        bit take;
        randomData();
        d[0] = 32'h1000 + WW'(sent);
        take = (sent < 5) && (model_q[0].size() < DEPTH);
        applyStimulus(1'b0, {1'b0, sent < 5}, {1'b0, guard[0] == 1'b0}, t, d);
        if (take) sent++;
        guard++;
      end
      checkOutput("wrap_done", 64'(sent == 5 && model_q[0].size() == 0), 64'(1));
    end

    // Reset with entries pending and ack low.
    for (int i = 0; i < 2; i++) begin
      randomData();
      applyStimulus(1'b0, 2'b10, 2'b00, t, d);
    end
    randomData();
    applyStimulus(1'b1, '0, 2'b00, t, d);
    checkOutput("rst_reqs", 64'(link_if.reqs), 64'(0));
    checkOutput("rst_quiescent", 64'(quiescent), 64'(1));
    checkOutput("rst_data", 64'(link_if.data_lines[1]), 64'(0));

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      randomData();
      applyStimulus($urandom_range(0, 59) == 0, P'($urandom), P'($urandom), t, d);
    end
    drainAll();

`ifdef TIA_LINK_SENDER_STATS_EN
    // Stall counter: 20 cycles, then saturation.
    randomData();
    applyStimulus(1'b1, '0, '0, t, d);
    applyStimulus(1'b0, 2'b01, 2'b00, t, d);
    for (int i = 0; i < 20; i++) begin
      randomData();
      applyStimulus(1'b0, '0, 2'b00, t, d);
    end
    checkOutput("stall_20", 64'(stall_count[0]), 64'(20));
    enq_valid    = '0;
    link_if.acks = '0;
    repeat (70000) @(posedge clock);
    #1;
    checkOutput("stall_sat", 64'(stall_count[0]), 64'(16'hFFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
